// File: rtl/tank_pkg.sv
// Shared constants for the tank state engine: opcodes, directions, wall codes
// and the reset corner placement of each tank.
package tank_pkg;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_WALL_WR = 3'd1;
  localparam logic [2:0] OP_MOVE    = 3'd2;
  localparam logic [2:0] OP_FIRE    = 3'd3;
  localparam logic [2:0] OP_STEP    = 3'd4;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int WALL_NONE  = 0;
  localparam int WALL_SOLID = 1;
  localparam int WALL_DESTR = 2;

  // Tanks start in alternating corners: 0 top-left, 1 bottom-right,
  // 2 top-right, 3 bottom-left; address is {row, col}.
  function automatic int unsigned corner_pos(input int t, input int g);
    int unsigned mx;
    mx = (32'd1 << g) - 32'd1;
    case (t)
      0:       return 32'd0;
      1:       return (mx << g) | mx;
      2:       return mx;
      default: return mx << g;
    endcase
  endfunction

  function automatic logic [1:0] corner_dir(input int t);
    return (t == 0 || t == 2) ? DIR_DOWN : DIR_UP;
  endfunction

endpackage

// File: rtl/grid_step.sv
// One-cell step on the {row, col} grid with out-of-bounds detection.
module grid_step
  import tank_pkg::*;
#(
  parameter int GRID_BITS = 4
) (
  input  logic [2*GRID_BITS-1:0] pos,
  input  logic [1:0]             dir,
  output logic [2*GRID_BITS-1:0] next_pos,
  output logic                   oob
);
  logic [GRID_BITS-1:0] row, col, nrow, ncol;

  assign row = pos[2*GRID_BITS-1:GRID_BITS];
  assign col = pos[GRID_BITS-1:0];

  always_comb begin
    nrow = row;
    ncol = col;
    oob  = 1'b0;
    case (dir)
      DIR_UP:    begin oob = (row == '0); nrow = row - 1'b1; end
      DIR_DOWN:  begin oob = (row == '1); nrow = row + 1'b1; end
      DIR_LEFT:  begin oob = (col == '0); ncol = col - 1'b1; end
      default:   begin oob = (col == '1); ncol = col + 1'b1; end
    endcase
  end

  assign next_pos = {nrow, ncol};
endmodule

// File: rtl/tank_state_engine.sv
// Tank/projectile state store with wall-map RAM, one command at a time.
// Define DESTRUCTIBLE_WALLS_EN to let projectiles clear code-2 walls.
module tank_state_engine
  import tank_pkg::*;
#(
  parameter int NUM_TANKS = 2,
  parameter int GRID_BITS = 4,
  parameter int WALL_W    = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [2:0]                       cmd_op,
  input  logic [1:0]                       cmd_id,
  input  logic [1:0]                       cmd_dir,
  input  logic [2*GRID_BITS-1:0]           cmd_addr,
  input  logic [WALL_W-1:0]                cmd_wall,
  output logic                             rsp_valid,
  output logic                             rsp_blocked,
  output logic [2*GRID_BITS-1:0]           rsp_pos,
  output logic [1:0]                       rsp_dir,
  output logic                             hit_valid,
  output logic [1:0]                       hit_shooter,
  output logic [1:0]                       hit_target,
  output logic [NUM_TANKS*2*GRID_BITS-1:0] tank_pos_flat,
  output logic [NUM_TANKS*2-1:0]           tank_dir_flat,
  output logic [NUM_TANKS*2*GRID_BITS-1:0] proj_pos_flat,
  output logic [NUM_TANKS-1:0]             proj_active
);
  localparam int AW = 2 * GRID_BITS;

  typedef enum logic [1:0] {IDLE, LOOKUP, EVAL} state_t;

  state_t                         state;
  logic [WALL_W-1:0]              wall_ram [2**AW];
  logic [NUM_TANKS-1:0][AW-1:0]   tank_pos, proj_pos;
  logic [NUM_TANKS-1:0][1:0]      tank_dir, proj_dir;
  logic [NUM_TANKS-1:0]           proj_act;

  logic [2:0]        op_q;
  logic [1:0]        id_q, dir_q;
  logic [AW-1:0]     tgt_q;
  logic              oob_q;
  logic [WALL_W-1:0] wall_q;

  // c_* select the tank named on cmd_id (IDLE), q_* the latched one (LOOKUP/EVAL)
  logic [AW-1:0] c_tpos, c_ppos, q_tpos, q_ppos;
  logic [1:0]    c_pdir, q_pdir, tgt_idx;
  logic          c_ok, c_pact, q_ok, q_pact, wr_occ, tgt_occ;

  always_comb begin
    c_tpos = '0; c_ppos = '0; c_pdir = '0; c_ok = 1'b0; c_pact = 1'b0;
    q_tpos = '0; q_ppos = '0; q_pdir = '0; q_ok = 1'b0; q_pact = 1'b0;
    wr_occ = 1'b0; tgt_occ = 1'b0; tgt_idx = '0;
    for (int t = 0; t < NUM_TANKS; t++) begin
      if (cmd_id == t[1:0]) begin
        c_ok = 1'b1; c_tpos = tank_pos[t]; c_ppos = proj_pos[t];
        c_pdir = proj_dir[t]; c_pact = proj_act[t];
      end
      if (id_q == t[1:0]) begin
        q_ok = 1'b1; q_tpos = tank_pos[t]; q_ppos = proj_pos[t];
        q_pdir = proj_dir[t]; q_pact = proj_act[t];
      end
      if (tank_pos[t] == cmd_addr) wr_occ = 1'b1;
      if (id_q != t[1:0] && tank_pos[t] == tgt_q) begin
        tgt_occ = 1'b1;
        tgt_idx = t[1:0];
      end
    end
  end

  logic [AW-1:0] step_pos, step_next;
  logic [1:0]    step_dir;
  logic          step_oob, wall_set, is_move;

  assign is_move  = (op_q == OP_MOVE);
  assign step_pos = is_move ? q_tpos : q_ppos;
  assign step_dir = is_move ? dir_q  : q_pdir;
  assign wall_set = (wall_q != '0);

  grid_step #(.GRID_BITS(GRID_BITS)) u_step (
    .pos      (step_pos),
    .dir      (step_dir),
    .next_pos (step_next),
    .oob      (step_oob)
  );

  assign cmd_ready     = (state == IDLE);
  assign tank_pos_flat = tank_pos;
  assign tank_dir_flat = tank_dir;
  assign proj_pos_flat = proj_pos;
  assign proj_active   = proj_act;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      rsp_valid   <= 1'b0;
      rsp_blocked <= 1'b0;
      rsp_pos     <= '0;
      rsp_dir     <= '0;
      hit_valid   <= 1'b0;
      hit_shooter <= '0;
      hit_target  <= '0;
      op_q        <= OP_NOP;
      id_q        <= '0;
      dir_q       <= '0;
      tgt_q       <= '0;
      oob_q       <= 1'b0;
      proj_act    <= '0;
      for (int t = 0; t < NUM_TANKS; t++) begin
        tank_pos[t] <= AW'(corner_pos(t, GRID_BITS));
        proj_pos[t] <= AW'(corner_pos(t, GRID_BITS));
        tank_dir[t] <= corner_dir(t);
        proj_dir[t] <= corner_dir(t);
      end
    end else begin
      rsp_valid <= 1'b0;
      hit_valid <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          op_q  <= cmd_op;
          id_q  <= cmd_id;
          dir_q <= cmd_dir;
          case (cmd_op)
            OP_NOP: begin
              rsp_valid   <= 1'b1;
              rsp_blocked <= 1'b0;
            end
            OP_WALL_WR: begin
              rsp_valid   <= 1'b1;
              rsp_blocked <= wr_occ;
              rsp_pos     <= cmd_addr;
              rsp_dir     <= '0;
            end
            OP_FIRE: begin
              rsp_valid <= 1'b1;
              if (!c_ok || c_pact) begin
                rsp_blocked <= 1'b1;
                rsp_pos     <= c_ppos;
                rsp_dir     <= c_pdir;
              end else begin
                rsp_blocked <= 1'b0;
                rsp_pos     <= c_tpos;
                rsp_dir     <= cmd_dir;
                for (int t = 0; t < NUM_TANKS; t++)
                  if (cmd_id == t[1:0]) begin
                    proj_pos[t] <= tank_pos[t];
                    proj_dir[t] <= cmd_dir;
                    tank_dir[t] <= cmd_dir;
                    proj_act[t] <= 1'b1;
                  end
              end
            end
            OP_MOVE, OP_STEP: state <= LOOKUP;
            default: begin
              rsp_valid   <= 1'b1;
              rsp_blocked <= 1'b1;
            end
          endcase
        end
        LOOKUP: begin
          tgt_q <= step_next;
          oob_q <= step_oob;
          state <= EVAL;
        end
        EVAL: begin
          state     <= IDLE;
          rsp_valid <= 1'b1;
          if (is_move) begin
            rsp_dir <= dir_q;
            for (int t = 0; t < NUM_TANKS; t++)
              if (id_q == t[1:0]) tank_dir[t] <= dir_q;
            if (!q_ok || oob_q || wall_set || tgt_occ) begin
              rsp_blocked <= 1'b1;
              rsp_pos     <= q_tpos;
            end else begin
              rsp_blocked <= 1'b0;
              rsp_pos     <= tgt_q;
              for (int t = 0; t < NUM_TANKS; t++)
                if (id_q == t[1:0]) tank_pos[t] <= tgt_q;
            end
          end else begin
            rsp_dir <= q_pdir;
            if (!q_ok || !q_pact) begin
              rsp_blocked <= 1'b1;
              rsp_pos     <= q_ppos;
            end else if (oob_q || wall_set) begin
              rsp_blocked <= 1'b1;
              rsp_pos     <= q_ppos;
              for (int t = 0; t < NUM_TANKS; t++)
                if (id_q == t[1:0]) proj_act[t] <= 1'b0;
            end else begin
              rsp_blocked <= 1'b0;
              rsp_pos     <= tgt_q;
              for (int t = 0; t < NUM_TANKS; t++)
                if (id_q == t[1:0]) begin
                  proj_pos[t] <= tgt_q;
                  if (tgt_occ) proj_act[t] <= 1'b0;
                end
              if (tgt_occ) begin
                hit_valid   <= 1'b1;
                hit_shooter <= id_q;
                hit_target  <= tgt_idx;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Wall map survives reset; writes are still suppressed while reset is low.
  always_ff @(posedge clk) begin
    if (reset && state == IDLE && cmd_valid && cmd_op == OP_WALL_WR && !wr_occ)
      wall_ram[cmd_addr] <= cmd_wall;
`ifdef DESTRUCTIBLE_WALLS_EN
    else if (reset && state == EVAL && op_q == OP_STEP && q_ok && q_pact && !oob_q &&
             wall_q == WALL_W'(WALL_DESTR))
      wall_ram[tgt_q] <= '0;
`endif
    if (state == LOOKUP) wall_q <= wall_ram[step_next];
  end

endmodule

// File: tb/tb_tank_state_engine.sv
// Self-checking bench for tank_state_engine: directed scenarios plus random
// commands checked against a row/column reference model.
module tb_tank_state_engine;
  localparam int NT = 2;
  localparam int G  = 4;
  localparam int M  = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid, cmd_ready;
  logic [2:0]       cmd_op;
  logic [1:0]       cmd_id, cmd_dir;
  logic [2*G-1:0]   cmd_addr;
  logic [1:0]       cmd_wall;
  logic             rsp_valid, rsp_blocked, hit_valid;
  logic [2*G-1:0]   rsp_pos;
  logic [1:0]       rsp_dir, hit_shooter, hit_target;
  logic [NT*8-1:0]  tank_pos_flat, proj_pos_flat;
  logic [NT*2-1:0]  tank_dir_flat;
  logic [NT-1:0]    proj_active;

  tank_state_engine #(.NUM_TANKS(NT), .GRID_BITS(G), .WALL_W(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_id(cmd_id), .cmd_dir(cmd_dir), .cmd_addr(cmd_addr),
    .cmd_wall(cmd_wall), .rsp_valid(rsp_valid), .rsp_blocked(rsp_blocked),
    .rsp_pos(rsp_pos), .rsp_dir(rsp_dir), .hit_valid(hit_valid),
    .hit_shooter(hit_shooter), .hit_target(hit_target),
    .tank_pos_flat(tank_pos_flat), .tank_dir_flat(tank_dir_flat),
    .proj_pos_flat(proj_pos_flat), .proj_active(proj_active)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int acc_cnt = 0;
  always @(posedge clk) if (reset && cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;

  // ---------------- reference model ----------------
  int trow[NT], tcol[NT], tdir[NT], prow[NT], pcol[NT], pdir[NT];
  bit pact[NT];
  int wmap[256];
  int e_lat, e_blk, e_pos, e_dir, e_hit, e_sh, e_tg;
  bit ck_pos, ck_dir, ck_blk;

  function automatic void model_reset();
    trow[0] = 0; tcol[0] = 0; tdir[0] = 1;
    trow[1] = M; tcol[1] = M; tdir[1] = 0;
    for (int t = 0; t < NT; t++) begin
      prow[t] = trow[t]; pcol[t] = tcol[t]; pdir[t] = tdir[t]; pact[t] = 0;
    end
  endfunction

  function automatic void next_cell(input int r, input int c, input int d,
                                    output int nr, output int nc, output bit oob);
    nr = r; nc = c;
    case (d)
      0: nr = r - 1;
      1: nr = r + 1;
      2: nc = c - 1;
      default: nc = c + 1;
    endcase
    oob = (nr < 0) || (nr > M) || (nc < 0) || (nc > M);
  endfunction

  function automatic int tank_at(input int r, input int c, input int skip);
    for (int t = 0; t < NT; t++)
      if (t != skip && trow[t] == r && tcol[t] == c) return t;
    return -1;
  endfunction

  function automatic void model_cmd(input int op, input int id, input int dir,
                                    input int addr, input int wall);
    int nr, nc, tg;
    bit oob;
    e_blk = 0; e_pos = 0; e_dir = 0; e_hit = 0; e_sh = 0; e_tg = 0;
    ck_pos = 0; ck_dir = 0; ck_blk = 1;
    case (op)
      0: e_lat = 1;
      1: begin
        e_lat = 1;
        e_blk = (tank_at(addr / 16, addr % 16, -1) >= 0) ? 1 : 0;
        if (e_blk == 0) wmap[addr] = wall;
      end
      3: begin
        e_lat = 1;
        if (pact[id]) e_blk = 1;
        else begin
          prow[id] = trow[id]; pcol[id] = tcol[id]; pdir[id] = dir;
          tdir[id] = dir; pact[id] = 1;
          ck_pos = 1; ck_dir = 1; e_pos = trow[id] * 16 + tcol[id]; e_dir = dir;
        end
      end
      2: begin
        e_lat = 3; ck_pos = 1; ck_dir = 1; e_dir = dir;
        tdir[id] = dir;
        next_cell(trow[id], tcol[id], dir, nr, nc, oob);
        if (oob) e_blk = 1;
        else if (wmap[nr * 16 + nc] != 0 || tank_at(nr, nc, id) >= 0) e_blk = 1;
        else begin trow[id] = nr; tcol[id] = nc; end
        e_pos = trow[id] * 16 + tcol[id];
      end
      default: begin
        e_lat = 3; ck_pos = 1; ck_dir = 1; e_dir = pdir[id];
        if (!pact[id]) e_blk = 1;
        else begin
          next_cell(prow[id], pcol[id], pdir[id], nr, nc, oob);
          if (oob) begin e_blk = 1; pact[id] = 0; end
          else if (wmap[nr * 16 + nc] != 0) begin
            e_blk = 1; pact[id] = 0;
`ifdef DESTRUCTIBLE_WALLS_EN
            if (wmap[nr * 16 + nc] == 2) wmap[nr * 16 + nc] = 0;
`endif
          end else begin
            prow[id] = nr; pcol[id] = nc;
            tg = tank_at(nr, nc, id);
            if (tg >= 0) begin
              e_hit = 1; e_sh = id; e_tg = tg; pact[id] = 0; ck_blk = 0;
            end
          end
        end
        e_pos = prow[id] * 16 + pcol[id];
      end
    endcase
  endfunction

  task automatic check_state(input string tag);
    logic [NT*8-1:0] tp, pp;
    logic [NT*2-1:0] td;
    logic [NT-1:0]   pa;
    for (int t = 0; t < NT; t++) begin
      tp[t*8 +: 8] = 8'(trow[t] * 16 + tcol[t]);
      pp[t*8 +: 8] = 8'(prow[t] * 16 + pcol[t]);
      td[t*2 +: 2] = 2'(tdir[t]);
      pa[t]        = pact[t];
    end
    check({tag, ".tank_pos"}, 32'(tank_pos_flat), 32'(tp));
    check({tag, ".tank_dir"}, 32'(tank_dir_flat), 32'(td));
    check({tag, ".proj_pos"}, 32'(proj_pos_flat), 32'(pp));
    check({tag, ".proj_act"}, 32'(proj_active), 32'(pa));
  endtask

  // ---------------- driver ----------------
  int r_lat, r_blk, r_pos, r_dir, r_hit, r_sh, r_tg;

  task automatic issue(input int op, input int id, input int dir, input int addr, input int wall);
    int n;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    check("ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = 3'(op); cmd_id = 2'(id); cmd_dir = 2'(dir);
    cmd_addr = 8'(addr); cmd_wall = 2'(wall);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_id = 2'($urandom);
    cmd_dir = 2'($urandom); cmd_addr = 8'($urandom); cmd_wall = 2'($urandom);
    r_lat = 0;
    do begin @(negedge clk); r_lat++; end while (!rsp_valid && r_lat < 10);
    r_blk = rsp_blocked; r_pos = rsp_pos; r_dir = rsp_dir;
    r_hit = hit_valid; r_sh = hit_shooter; r_tg = hit_target;
  endtask

  task automatic run_cmd(input string tag, input int op, input int id, input int dir,
                         input int addr, input int wall);
    issue(op, id, dir, addr, wall);
    model_cmd(op, id, dir, addr, wall);
    check({tag, ".lat"}, r_lat, e_lat);
    if (ck_blk) check({tag, ".blocked"}, r_blk, e_blk);
    if (ck_pos) check({tag, ".pos"}, r_pos, e_pos);
    if (ck_dir) check({tag, ".dir"}, r_dir, e_dir);
    check({tag, ".hit"}, r_hit, e_hit);
    if (e_hit != 0) begin
      check({tag, ".shooter"}, r_sh, e_sh);
      check({tag, ".target"}, r_tg, e_tg);
    end
    check_state(tag);
  endtask

  int low_cnt, acc0, seen, op, w;

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_id = '0; cmd_dir = '0;
    cmd_addr = '0; cmd_wall = '0;
    foreach (wmap[a]) wmap[a] = 0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // reset state
    check("rst.tank_pos", 32'(tank_pos_flat), 32'h0000_FF00);
    check("rst.tank_dir", 32'(tank_dir_flat), 32'h0000_0001);
    check("rst.proj_act", 32'(proj_active), 32'd0);
    check("rst.ready", 32'(cmd_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check_state("rst");

    // clear the wall map (corner cells are taken by tanks and get fixed below)
    for (int a = 0; a < 256; a++) begin
      issue(1, 0, 0, a, 0);
      check("clr.blocked", r_blk, (a == 8'h00 || a == 8'hFF) ? 1 : 0);
    end

    // moves at the edge, latency
    run_cmd("mv_up", 2, 0, 0, 0, 0);
    check("mv_up.blk_const", r_blk, 1);
    check("mv_up.pos_const", r_pos, 8'h00);
    run_cmd("mv_dn", 2, 0, 1, 0, 0);
    check("mv_dn.pos_const", r_pos, 8'h10);
    check("mv_dn.lat_const", r_lat, 3);
    run_cmd("clr00", 1, 0, 0, 8'h00, 0);
    run_cmd("t1_up", 2, 1, 0, 0, 0);
    run_cmd("clrFF", 1, 0, 0, 8'hFF, 0);
    run_cmd("t1_dn", 2, 1, 1, 0, 0);

    // walls block moves; occupied cell rejects a write
    run_cmd("w20", 1, 0, 0, 8'h20, 1);
    run_cmd("mv_wall", 2, 0, 1, 0, 0);
    check("mv_wall.blk_const", r_blk, 1);
    run_cmd("wFF", 1, 0, 0, 8'hFF, 1);
    check("wFF.blk_const", r_blk, 1);

    // walk tank0 to the bottom-left corner and shoot it from tank1
    run_cmd("w20clr", 1, 0, 0, 8'h20, 0);
    for (int i = 0; i < 14; i++) run_cmd("walk", 2, 0, 1, 0, 0);
    check("walk.pos_const", r_pos, 8'hF0);
    run_cmd("fire1", 3, 1, 2, 0, 0);
    check("fire1.pos_const", r_pos, 8'hFF);
    for (int i = 0; i < 15; i++) run_cmd("step", 4, 1, 0, 0, 0);
    check("step15.hit_const", r_hit, 1);
    check("step15.shooter_const", r_sh, 1);
    check("step15.target_const", r_tg, 0);
    check("step15.pos_const", r_pos, 8'hF0);
    check("step15.act_const", 32'(proj_active), 32'd0);
    run_cmd("step16", 4, 1, 0, 0, 0);
    check("step16.blk_const", r_blk, 1);

    // cmd_valid held high across a move
    @(negedge clk);
    acc0 = acc_cnt; low_cnt = 0;
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_id = 2'd0; cmd_dir = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!cmd_ready) low_cnt++;
    end
    cmd_valid = 1'b0;
    r_blk = rsp_blocked; r_pos = rsp_pos;
    check("hold.rsp_valid", 32'(rsp_valid), 32'd1);
    check("hold.ready_low", low_cnt, 2);
    check("hold.accepts", acc_cnt - acc0, 1);
    model_cmd(2, 0, 0, 0, 0);
    check("hold.pos", r_pos, e_pos);
    check_state("hold");
    run_cmd("fire0", 3, 0, 3, 0, 0);
    run_cmd("fire0b", 3, 0, 3, 0, 0);
    check("fire0b.blk_const", r_blk, 1);

    // reset during EVAL; walls persist
    run_cmd("w01", 1, 0, 0, 8'h01, 1);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_id = 2'd1; cmd_dir = 2'd2;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (2) begin @(negedge clk); if (rsp_valid) seen = 1; end
    reset = 1'b1;
    repeat (4) begin @(negedge clk); if (rsp_valid) seen = 1; end
    check("rstmid.no_rsp", seen, 0);
    model_reset();
    check_state("rstmid");
    run_cmd("persist", 2, 0, 3, 0, 0);
    check("persist.blk_const", r_blk, 1);

    // projectile into a code-2 wall, then again through the same cell
    run_cmd("w30", 1, 0, 0, 8'h30, 2);
    run_cmd("fireD", 3, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) run_cmd("stepD", 4, 0, 0, 0, 0);
    check("stepD.blk_const", r_blk, 1);
    run_cmd("fireD2", 3, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) run_cmd("stepD2", 4, 0, 0, 0, 0);
`ifdef DESTRUCTIBLE_WALLS_EN
    check("stepD2.blk_const", r_blk, 0);
    check("stepD2.pos_const", r_pos, 8'h30);
`else
    check("stepD2.blk_const", r_blk, 1);
`endif

    // random commands against the model
    for (int i = 0; i < 300; i++) begin
      w = $urandom_range(13, 0);
      op = (w < 1) ? 0 : (w < 3) ? 1 : (w < 7) ? 2 : (w < 9) ? 3 : 4;
      run_cmd("rnd", op, $urandom_range(1, 0), $urandom_range(3, 0),
              $urandom_range(255, 0), ($urandom_range(3, 0) < 2) ? 0 : $urandom_range(2, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
